// File: rtl/jtag_chain_engine_if.sv
// Host-side byte streams and per-chain JTAG pins of jtag_chain_engine, bundled as one port.
// The engine connects through the slave modport; the host side uses master.
interface jtag_chain_engine_if #(
    parameter int N_CHAINS = 2,
    parameter int SEL_W    = (N_CHAINS > 1) ? $clog2(N_CHAINS) : 1
);
    logic [7:0]          i_cmd_data;
    logic                i_cmd_valid;
    logic                o_cmd_ready;
    logic [SEL_W-1:0]    i_chain_sel;
    logic [7:0]          o_rsp_data;
    logic                o_rsp_valid;
    logic                i_rsp_ready;
    logic [N_CHAINS-1:0] o_tck;
    logic [N_CHAINS-1:0] o_tms;
    logic [N_CHAINS-1:0] o_tdi;
    logic [N_CHAINS-1:0] i_tdo;
    logic                o_busy;

    modport slave (
        input  i_cmd_data, i_cmd_valid, i_chain_sel, i_rsp_ready, i_tdo,
        output o_cmd_ready, o_rsp_data, o_rsp_valid, o_tck, o_tms, o_tdi, o_busy
    );

    modport master (
        output i_cmd_data, i_cmd_valid, i_chain_sel, i_rsp_ready, i_tdo,
        input  o_cmd_ready, o_rsp_data, o_rsp_valid, o_tck, o_tms, o_tdi, o_busy
    );
endinterface

// File: rtl/jtag_chain_engine.sv
// Byte-stream driven JTAG master: bit-bang commands drive TCK/TMS/TDI directly, shift
// commands clock whole bytes out LSB first with a CLK_DIV-cycle TCK half-period.
module jtag_chain_engine #(
    parameter int N_CHAINS = 2,
    parameter int CLK_DIV  = 2,
    parameter int SEL_W    = (N_CHAINS > 1) ? $clog2(N_CHAINS) : 1
) (
    input logic                i_clk,
    input logic                i_reset_n,
    jtag_chain_engine_if.slave bus
);

    localparam logic [1:0] S_CMD  = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;
    localparam logic [1:0] S_HIGH = 2'd3;

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    function automatic logic [N_CHAINS-1:0] chain_mask(input logic [SEL_W-1:0] sel);
        logic [N_CHAINS-1:0] m;
        m = '0;
        for (int i = 0; i < N_CHAINS; i++) begin
            if (sel == SEL_W'(i)) m[i] = 1'b1;
        end
        return m;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [5:0]       count_q, count_d;
    logic             read_q, read_d;
    logic [6:0]       shreg_q, shreg_d;
    logic [7:0]       rsp_shift_q, rsp_shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tck_q, tck_d;
    logic             tms_q, tms_d;
    logic             tdi_q, tdi_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;

    logic                cmd_ready;
    logic                cmd_fire;
    logic                sel_ok;
    logic [SEL_W-1:0]    sel_next;
    logic [N_CHAINS-1:0] mask_q;
    logic                tdo_cur;
    logic                tdo_next;
    logic [7:0]          cmd;

    assign cmd       = bus.i_cmd_data;
    assign cmd_ready = ((state_q == S_CMD) || (state_q == S_DATA)) && !rsp_valid_q;
    assign cmd_fire  = bus.i_cmd_valid && cmd_ready;

    // Out-of-range selections are dropped so the engine never addresses a missing chain.
    assign sel_ok   = ({1'b0, bus.i_chain_sel} < (SEL_W + 1)'(N_CHAINS));
    assign sel_next = sel_ok ? bus.i_chain_sel : sel_q;
    assign mask_q   = chain_mask(sel_q);
    assign tdo_cur  = |(bus.i_tdo & mask_q);
    assign tdo_next = |(bus.i_tdo & chain_mask(sel_next));

    assign bus.o_cmd_ready = cmd_ready;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_busy      = (state_q != S_CMD);
    assign bus.o_tck       = tck_q ? mask_q : '0;
    assign bus.o_tms       = tms_q ? mask_q : '0;
    assign bus.o_tdi       = tdi_q ? mask_q : '0;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path infers a latch.
        state_d     = state_q;
        sel_d       = sel_q;
        count_d     = count_q;
        read_d      = read_q;
        shreg_d     = shreg_q;
        rsp_shift_d = rsp_shift_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;

        if (rsp_valid_q && bus.i_rsp_ready) rsp_valid_d = 1'b0;

        case (state_q)
            S_CMD: begin
                if (cmd_fire) begin
                    sel_d = sel_next;
                    if (sel_next != sel_q) begin
                        tck_d = 1'b0;
                        tms_d = 1'b0;
                        tdi_d = 1'b0;
                    end
                    if (!cmd[7]) begin
                        tck_d = cmd[0];
                        tms_d = cmd[1];
                        tdi_d = cmd[4];
                        if (cmd[6]) begin
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = {7'b0, tdo_next};
                        end
                    end else begin
                        count_d = cmd[5:0];
                        read_d  = cmd[6];
                        if (cmd[5:0] != 6'd0) begin
                            tck_d   = 1'b0;
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (cmd_fire) begin
                    tdi_d     = cmd[0];
                    shreg_d   = cmd[7:1];
                    bit_cnt_d = 3'd0;
                    div_cnt_d = '0;
                    state_d   = S_LOW;
                end
            end
            S_LOW: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d   = '0;
                    tck_d       = 1'b1;
                    rsp_shift_d = {tdo_cur, rsp_shift_q[7:1]};
                    state_d     = S_HIGH;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    tck_d     = 1'b0;
                    if (bit_cnt_q == 3'd7) begin
                        count_d = count_q - 6'd1;
                        if (read_q) begin
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = rsp_shift_q;
                        end
                        state_d = (count_q == 6'd1) ? S_CMD : S_DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tdi_d     = shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[6:1]};
                        state_d   = S_LOW;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= S_CMD;
            sel_q       <= '0;
            count_q     <= '0;
            read_q      <= 1'b0;
            shreg_q     <= '0;
            rsp_shift_q <= '0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b0;
            tdi_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            count_q     <= count_d;
            read_q      <= read_d;
            shreg_q     <= shreg_d;
            rsp_shift_q <= rsp_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_jtag_chain_engine.sv
// Directed bench for jtag_chain_engine: bit-bang, shifted bytes with TDO loopback,
// response backpressure, zero-length shift, invalid chain select and mid-shift reset.
module tb_jtag_chain_engine;

    localparam int N   = 2;
    localparam int DIV = 2;
    localparam int SW  = 2;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         loop_en;
    logic [N-1:0] tdo_man;
    int           total = 0;
    int           bad   = 0;
    int           cyc;
    int           pls;
    int           odd;

    always #5 clk = ~clk;

    jtag_chain_engine_if #(.N_CHAINS(N), .SEL_W(SW)) bus ();

    jtag_chain_engine #(.N_CHAINS(N), .CLK_DIV(DIV), .SEL_W(SW)) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    always_comb bus.i_tdo = loop_en ? bus.o_tdi : tdo_man;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the transfer edge.
    task automatic send(input logic [7:0] d, input logic [SW-1:0] s);
        int n = 0;
        bus.i_cmd_data  = d;
        bus.i_chain_sel = s;
        bus.i_cmd_valid = 1'b1;
        while (!bus.o_cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready_in_time", 32'(n < 200), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.i_cmd_valid = 1'b0;
    endtask

    task automatic accept();
        bus.i_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_rsp_ready = 1'b0;
    endtask

    // Sends one data byte on chain 1, then counts cycles until the response and TCK rising edges.
    task automatic run_byte(input logic [7:0] d, output int cycles, output int pulses);
        logic prev;
        send(d, 2'd1);
        cycles = -1;
        pulses = 0;
        prev   = bus.o_tck[1];
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (bus.o_tck[1] && !prev) pulses++;
            prev = bus.o_tck[1];
            if (bus.o_rsp_valid) begin
                cycles = k;
                break;
            end
        end
    endtask

    initial begin
        bus.i_cmd_data  = 8'h00;
        bus.i_cmd_valid = 1'b0;
        bus.i_chain_sel = '0;
        bus.i_rsp_ready = 1'b0;
        loop_en         = 1'b0;
        tdo_man         = '0;

        repeat (2) @(negedge clk);
        chk("rst_tck", 32'(bus.o_tck), 32'h0);
        chk("rst_tms", 32'(bus.o_tms), 32'h0);
        chk("rst_tdi", 32'(bus.o_tdi), 32'h0);
        chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'h0);
        chk("rst_rsp_data", 32'(bus.o_rsp_data), 32'h0);
        chk("rst_busy", 32'(bus.o_busy), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.o_cmd_ready), 32'h1);

        // Invalid select 3 keeps chain 0.
        send(8'h01, 2'd3);
        chk("badsel_tck", 32'(bus.o_tck), 32'h1);
        chk("badsel_tms", 32'(bus.o_tms), 32'h0);
        chk("badsel_tdi", 32'(bus.o_tdi), 32'h0);
        chk("badsel_rsp_valid", 32'(bus.o_rsp_valid), 32'h0);

        // Bit-bang 0x53 on chain 1 with TDO[1]=1.
        tdo_man = 2'b10;
        send(8'h53, 2'd1);
        chk("bb_tck", 32'(bus.o_tck), 32'h2);
        chk("bb_tms", 32'(bus.o_tms), 32'h2);
        chk("bb_tdi", 32'(bus.o_tdi), 32'h2);
        chk("bb_rsp_valid", 32'(bus.o_rsp_valid), 32'h1);
        chk("bb_rsp_data", 32'(bus.o_rsp_data), 32'h01);
        chk("bb_ready_blocked", 32'(bus.o_cmd_ready), 32'h0);
        accept();
        chk("bb_rsp_taken", 32'(bus.o_rsp_valid), 32'h0);

        // Two-byte read shift with loopback.
        loop_en = 1'b1;
        send(8'hC2, 2'd1);
        chk("shift_tck_low", 32'(bus.o_tck), 32'h0);
        chk("shift_tms_hold", 32'(bus.o_tms), 32'h2);
        chk("shift_busy", 32'(bus.o_busy), 32'h1);
        run_byte(8'hA5, cyc, pls);
        chk("a5_cycles", 32'(cyc), 32'd32);
        chk("a5_pulses", 32'(pls), 32'd8);
        chk("a5_data", 32'(bus.o_rsp_data), 32'hA5);
        chk("a5_tms_hold", 32'(bus.o_tms), 32'h2);
        chk("a5_tck_low", 32'(bus.o_tck), 32'h0);
        accept();
        run_byte(8'h3C, cyc, pls);
        chk("3c_cycles", 32'(cyc), 32'd32);
        chk("3c_pulses", 32'(pls), 32'd8);
        chk("3c_data", 32'(bus.o_rsp_data), 32'h3C);
        chk("3c_back_to_cmd", 32'(bus.o_busy), 32'h0);
        accept();

        // Response backpressure for 50 cycles with a command pending.
        send(8'hC1, 2'd1);
        run_byte(8'hFF, cyc, pls);
        chk("ff_data", 32'(bus.o_rsp_data), 32'hFF);
        bus.i_cmd_data  = 8'h01;
        bus.i_chain_sel = 2'd1;
        bus.i_cmd_valid = 1'b1;
        odd = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.o_cmd_ready || !bus.o_rsp_valid || bus.o_tck[1] || bus.o_rsp_data != 8'hFF) odd++;
        end
        chk("bp_held_50", 32'(odd), 32'd0);
        chk("bp_ready_low", 32'(bus.o_cmd_ready), 32'h0);
        bus.i_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_rsp_ready = 1'b0;
        chk("bp_rsp_taken", 32'(bus.o_rsp_valid), 32'h0);
        chk("bp_cmd_not_yet", 32'(bus.o_tck), 32'h0);
        @(posedge clk);
        @(negedge clk);
        bus.i_cmd_valid = 1'b0;
        chk("bp_cmd_after", 32'(bus.o_tck), 32'h2);

        // Zero-length shift leaves pins and state alone.
        send(8'h80, 2'd1);
        odd = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.o_busy || bus.o_rsp_valid || bus.o_tck != 2'b10) odd++;
        end
        chk("zero_shift_quiet", 32'(odd), 32'd0);
        send(8'h00, 2'd1);
        chk("zero_shift_next_cmd", 32'(bus.o_tck), 32'h0);

        // Reset during bit 4 of a shifted byte.
        send(8'hC3, 2'd1);
        send(8'h5A, 2'd1);
        repeat (18) @(negedge clk);
        chk("mid_tck_high", 32'(bus.o_tck), 32'h2);
        chk("mid_tdi_bit4", 32'(bus.o_tdi), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_tck", 32'(bus.o_tck), 32'h0);
        chk("async_tms", 32'(bus.o_tms), 32'h0);
        chk("async_tdi", 32'(bus.o_tdi), 32'h0);
        chk("async_rsp_valid", 32'(bus.o_rsp_valid), 32'h0);
        chk("async_rsp_data", 32'(bus.o_rsp_data), 32'h0);
        chk("async_busy", 32'(bus.o_busy), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        odd = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_rsp_valid || bus.o_busy || !bus.o_cmd_ready) odd++;
        end
        chk("post_reset_idle", 32'(odd), 32'd0);
        send(8'h41, 2'd3);
        chk("post_reset_sel0_tck", 32'(bus.o_tck), 32'h1);
        chk("post_reset_rsp_valid", 32'(bus.o_rsp_valid), 32'h1);
        chk("post_reset_rsp_data", 32'(bus.o_rsp_data), 32'h0);
        accept();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtag_chain_engine.md
JTAG_CHAIN_ENGINE -- requirements
Module: jtag_chain_engine

Interface
REQ-001 SHALL have parameter N_CHAINS, default 2, number of JTAG chains driven (legal 1..8).
REQ-002 SHALL have parameter CLK_DIV, default 2, i_clk cycles per TCK half-period (legal >=1).
REQ-003 SHALL have parameter SEL_W, default $clog2(N_CHAINS) or 1 if N_CHAINS==1, chain-select width.
REQ-004 SHALL provide i_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL provide i_reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL provide i_cmd_data  in  8  command/data byte stream.
REQ-007 SHALL provide i_cmd_valid  in  1  and o_cmd_ready  out  1; a byte transfers when both are high on a clock edge.
REQ-008 SHALL provide i_chain_sel  in  SEL_W  target chain, sampled only on command-byte transfer.
REQ-009 SHALL provide o_rsp_data  out  8, o_rsp_valid  out  1, i_rsp_ready  in  1; response transfers when valid and ready are both high.
REQ-010 SHALL provide o_tck, o_tms, o_tdi  out  N_CHAINS each, one bit per chain; i_tdo  in  N_CHAINS, already synchronised upstream.
REQ-011 SHALL provide o_busy  out  1, high whenever state is not S_CMD.

Function
REQ-012 SHALL implement states S_CMD, S_DATA, S_LOW, S_HIGH.
REQ-013 o_cmd_ready SHALL be high only in S_CMD or S_DATA and only while o_rsp_valid is low.
REQ-014 In S_CMD, a byte with bit7=0 (bit-bang) SHALL set the selected chain's TCK=bit0, TMS=bit1, TDI=bit4 on the next cycle; bits 2,3,5 ignored; state stays S_CMD.
REQ-015 Bit-bang with bit6=1 SHALL assert o_rsp_valid the next cycle with o_rsp_data = {7'b0, i_tdo[sel]}, i_tdo sampled on the transfer cycle.
REQ-016 In S_CMD, a byte with bit7=1 (shift) SHALL latch count=bit5:0 and read=bit6; count==0 returns to S_CMD with no effect; else go to S_DATA.
REQ-017 Entering shift mode SHALL force TCK low and hold TMS at its last bit-bang value for the whole shift.
REQ-018 In S_DATA, each transferred byte SHALL be shifted LSB first: per bit, TDI=bit and TCK low for CLK_DIV cycles (S_LOW), TCK high for CLK_DIV cycles (S_HIGH).
REQ-019 TDO SHALL be sampled on the cycle TCK rises; sampled bits assemble LSB first into the response byte.
REQ-020 One data byte SHALL take exactly 16*CLK_DIV cycles from transfer to TCK falling after bit 7.
REQ-021 If read=1, o_rsp_valid SHALL assert the cycle after bit 7 completes with the assembled byte.
REQ-022 After each byte count SHALL decrement; count reaching 0 returns to S_CMD, else S_DATA.
REQ-023 o_rsp_valid SHALL stay high, data stable, until accepted; no new byte is accepted meanwhile (backpressure).
REQ-024 Chain select SHALL latch on each S_CMD transfer; value >= N_CHAINS SHALL be ignored and the previous selection kept.
REQ-025 Unselected chains SHALL drive TCK=0, TMS=0, TDI=0; on a selection change the new chain starts from TCK=0, TMS=0, TDI=0.
REQ-026 i_chain_sel changes while in S_DATA/S_LOW/S_HIGH SHALL have no effect.

Reset
REQ-027 Asserting i_reset_n low SHALL immediately force S_CMD, all o_tck/o_tms/o_tdi=0, o_rsp_valid=0, o_rsp_data=0, selection=0, count=0, o_busy=0.
REQ-028 Reset mid-shift SHALL abandon the byte and remaining count; no response is produced.
REQ-029 o_cmd_ready SHALL be high on the first clock edge after reset deassertion.

Verification
REQ-030 Bit-bang 0x53 on chain 1, i_tdo[1]=1 -> next cycle o_tck[1]=1, o_tms[1]=1, o_tdi[1]=1; o_rsp_data=0x01 valid.
REQ-031 Shift 0xC2 then 0xA5, 0x3C with CLK_DIV=2, TDO loopback from TDI -> 8 TCK pulses per byte, 32 cycles per byte, responses 0xA5 then 0x3C, back to S_CMD.
REQ-032 Shift 0xC1, data 0xFF, i_rsp_ready=0 for 50 cycles -> o_rsp_valid held, o_cmd_ready=0, next command accepted only after response taken.
REQ-033 Shift 0x80 (count 0) -> state remains S_CMD, no TCK edge, no response, next byte treated as command.
REQ-034 N_CHAINS=2, i_chain_sel=3 with bit-bang 0x01 -> chain 0 TCK=1, chain 1 untouched.
REQ-035 Reset asserted during bit 4 of a shift -> all outputs 0 same cycle, no response, accepts command after release.
